// File: rtl/conv_window_gen_pkg.sv
// Shared defaults, FSM encoding and window-slice indices for the 3x3 window generator.
package conv_window_gen_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_MAX_W  = 58;
  localparam int DEF_MAX_H  = 58;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Slice k of the window bus sits at [k*DATA_W +: DATA_W], row-major, top-left first.
  localparam int WIN_TL = 0;
  localparam int WIN_TM = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MM = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BM = 7;
  localparam int WIN_BR = 8;

endpackage

// File: rtl/conv_window_gen_line_mem.sv
// One image row of pixels: combinational read, synchronous write to the same address
// (read-before-write). Contents are not reset; an SRAM macro can replace this later.
module line_mem #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 58,
  parameter int AW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Stall-aware 3x3 sliding-window generator with runtime image size; pixels advance only
// on in_valid, each window is tagged with row/col and end-of-frame one cycle after the accept.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int MAX_H  = DEF_MAX_H,
  parameter int CW     = $clog2(MAX_W + 1),
  parameter int CH     = $clog2(MAX_H + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       cfg_width,
  input  logic [CH-1:0]       cfg_height,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  output logic [9*DATA_W-1:0] win,
  output logic [CH-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                frame_done,
  output logic                busy,
  output logic                cfg_err
);

  state_e              state_q, state_d;
  logic [CW-1:0]       w_q, w_d, c_q, c_d, out_col_q;
  logic [CH-1:0]       h_q, h_d, r_q, r_d, out_row_q;
  logic                err_q, err_d;
  logic                out_valid_q, frame_done_q;
  logic [9*DATA_W-1:0] win_q;
  logic [DATA_W-1:0]   rd0, rd1;

  logic accept, cfg_ok, last_col, last_pix, win_ok;

  assign busy     = (state_q == ST_RUN);
  assign accept   = in_valid && busy;
  assign cfg_ok   = (cfg_width  >= CW'(3)) && (cfg_width  <= CW'(MAX_W)) &&
                    (cfg_height >= CH'(3)) && (cfg_height <= CH'(MAX_H));
  assign last_col = (c_q == w_q - CW'(1));
  assign last_pix = last_col && (r_q == h_q - CH'(1));
  // Columns 0/1 of a row still hold the previous row's tail, so they never form a window.
  assign win_ok   = (r_q >= CH'(2)) && (c_q >= CW'(2));

  line_mem #(.DATA_W(DATA_W), .DEPTH(MAX_W), .AW(CW)) u_mem0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (c_q),
    .wdata_i (rd1),
    .rdata_o (rd0)
  );

  line_mem #(.DATA_W(DATA_W), .DEPTH(MAX_W), .AW(CW)) u_mem1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (c_q),
    .wdata_i (in_data),
    .rdata_o (rd1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // A start in the same cycle as an accept overrides the counter advance but not the output.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    r_d     = r_q;
    c_d     = c_q;
    err_d   = err_q;
    if (accept) begin
      if (last_col) begin
        c_d = '0;
        r_d = r_q + CH'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
      if (last_pix) state_d = ST_IDLE;
    end
    if (start) begin
      if (cfg_ok) begin
        state_d = ST_RUN;
        w_d     = cfg_width;
        h_d     = cfg_height;
        r_d     = '0;
        c_d     = '0;
        err_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= accept && win_ok;
      frame_done_q <= accept && last_pix;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[(3*i)*DATA_W   +: DATA_W] <= win_q[(3*i+1)*DATA_W +: DATA_W];
          win_q[(3*i+1)*DATA_W +: DATA_W] <= win_q[(3*i+2)*DATA_W +: DATA_W];
        end
        win_q[WIN_TR*DATA_W +: DATA_W] <= rd0;
        win_q[WIN_MR*DATA_W +: DATA_W] <= rd1;
        win_q[WIN_BR*DATA_W +: DATA_W] <= in_data;
      end
      if (accept && win_ok) begin
        out_row_q <= r_q - CH'(2);
        out_col_q <= c_q - CW'(2);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win        = win_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign cfg_err    = err_q;

endmodule
